// File: rtl/wb_stream_loader.sv
// Boot loader: receives a length-prefixed little-endian word image over a byte
// stream, writes it to program memory as Wishbone single-beat cycles, then releases core reset.
module wb_stream_loader #(
   parameter logic [31:0] BASE_ADR    = 32'h0000_0000,
   parameter int unsigned MAX_WORDS   = 16384,
   parameter int unsigned ACK_TIMEOUT = 256
) (
   input  logic        clk,
   input  logic        i_rst,
   input  logic        i_byte_valid,
   input  logic [7:0]  i_byte_data,
   output logic        o_byte_ready,
   output logic [31:0] o_wb_adr,
   output logic [31:0] o_wb_dat,
   output logic [3:0]  o_wb_sel,
   output logic        o_wb_we,
   output logic        o_wb_cyc,
   input  logic        i_wb_ack,
   output logic        o_core_rst,
   output logic        o_done,
   output logic        o_err,
   output logic [31:0] o_words_written
);

   localparam logic [31:0] MAX_W  = 32'(MAX_WORDS);
   localparam logic [31:0] ACK_TO = 32'(ACK_TIMEOUT);

   typedef enum logic [2:0] {
      S_LEN,
      S_DATA,
      S_WRITE,
      S_DONE,
      S_ERR
   } state_t;

   state_t      state;
   logic [1:0]  byte_cnt;
   logic [31:0] shift_q;
   logic [31:0] len_q;
   logic [31:0] tmo_cnt;

   logic        byte_fire;
   logic        last_byte;
   logic [31:0] word_in;
   logic [31:0] adr_sum;

   // Incoming byte lands in [31:24]; after four bytes the first one sits in [7:0].
   assign byte_fire = i_byte_valid & o_byte_ready;
   assign last_byte = byte_fire && (byte_cnt == 2'd3);
   assign word_in   = {i_byte_data, shift_q[31:8]};
   assign adr_sum   = BASE_ADR + {o_words_written[29:0], 2'b00};

   // NOTE: every register here is state, so all assignments are non-blocking and
   // the synchronous reset branch gives each one a defined value.
   always_ff @(posedge clk) begin
      if (i_rst) begin
         state           <= S_LEN;
         byte_cnt        <= 2'd0;
         shift_q         <= 32'd0;
         len_q           <= 32'd0;
         tmo_cnt         <= 32'd0;
         o_byte_ready    <= 1'b0;
         o_wb_adr        <= 32'd0;
         o_wb_dat        <= 32'd0;
         o_wb_sel        <= 4'b0000;
         o_wb_we         <= 1'b0;
         o_wb_cyc        <= 1'b0;
         o_core_rst      <= 1'b1;
         o_done          <= 1'b0;
         o_err           <= 1'b0;
         o_words_written <= 32'd0;
      end else begin
         if (byte_fire) begin
            shift_q  <= word_in;
            byte_cnt <= byte_cnt + 2'd1;
         end

         case (state)
            S_LEN: begin
               if (last_byte) begin
                  len_q <= word_in;
                  if (word_in == 32'd0) begin
                     state        <= S_DONE;
                     o_done       <= 1'b1;
                     o_core_rst   <= 1'b0;
                     o_byte_ready <= 1'b0;
                  end else if (word_in > MAX_W) begin
                     state        <= S_ERR;
                     o_err        <= 1'b1;
                     o_byte_ready <= 1'b0;
                  end else begin
                     state <= S_DATA;
                  end
               end else begin
                  o_byte_ready <= 1'b1;
               end
            end

            S_DATA: begin
               if (last_byte) begin
                  state        <= S_WRITE;
                  o_byte_ready <= 1'b0;
                  o_wb_cyc     <= 1'b1;
                  o_wb_we      <= 1'b1;
                  o_wb_sel     <= 4'b1111;
                  o_wb_adr     <= {adr_sum[31:2], 2'b00};
                  o_wb_dat     <= word_in;
                  tmo_cnt      <= 32'd0;
               end
            end

            S_WRITE: begin
               if (i_wb_ack) begin
                  o_wb_cyc        <= 1'b0;
                  o_wb_we         <= 1'b0;
                  o_wb_sel        <= 4'b0000;
                  o_words_written <= o_words_written + 32'd1;
                  if (o_words_written + 32'd1 == len_q) begin
                     state      <= S_DONE;
                     o_done     <= 1'b1;
                     o_core_rst <= 1'b0;
                  end else begin
                     state        <= S_DATA;
                     o_byte_ready <= 1'b1;
                  end
               end else if ((ACK_TO != 32'd0) && (tmo_cnt == ACK_TO - 32'd1)) begin
                  // Give up on the responder: abandon the word and stop for good.
                  state    <= S_ERR;
                  o_err    <= 1'b1;
                  o_wb_cyc <= 1'b0;
                  o_wb_we  <= 1'b0;
                  o_wb_sel <= 4'b0000;
               end else begin
                  tmo_cnt <= tmo_cnt + 32'd1;
               end
            end

            default: begin
               o_byte_ready <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_wb_stream_loader.sv
// Directed bench for wb_stream_loader: length-stage vector table, then hand
// sequences for writes, address wrap, valid gaps, ack timeout and mid-cycle reset.
module tb_wb_stream_loader;

   localparam logic [31:0] BASE = 32'hFFFF_FFF8;

   logic        clk = 1'b0;
   logic        i_rst;
   logic        i_byte_valid;
   logic [7:0]  i_byte_data;
   logic        o_byte_ready;
   logic [31:0] o_wb_adr;
   logic [31:0] o_wb_dat;
   logic [3:0]  o_wb_sel;
   logic        o_wb_we;
   logic        o_wb_cyc;
   logic        i_wb_ack;
   logic        o_core_rst;
   logic        o_done;
   logic        o_err;
   logic [31:0] o_words_written;

   always #5 clk = ~clk;

   wb_stream_loader #(
      .BASE_ADR   (BASE),
      .MAX_WORDS  (4),
      .ACK_TIMEOUT(16)
   ) dut (
      .clk            (clk),
      .i_rst          (i_rst),
      .i_byte_valid   (i_byte_valid),
      .i_byte_data    (i_byte_data),
      .o_byte_ready   (o_byte_ready),
      .o_wb_adr       (o_wb_adr),
      .o_wb_dat       (o_wb_dat),
      .o_wb_sel       (o_wb_sel),
      .o_wb_we        (o_wb_we),
      .o_wb_cyc       (o_wb_cyc),
      .i_wb_ack       (i_wb_ack),
      .o_core_rst     (o_core_rst),
      .o_done         (o_done),
      .o_err          (o_err),
      .o_words_written(o_words_written)
   );

   int checks = 0;
   int errors = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // Responder and monitor, evaluated on the falling edge away from DUT updates
   typedef struct {
      logic [31:0] adr;
      logic [31:0] dat;
      logic [3:0]  sel;
      logic        we;
   } wr_t;

   wr_t         wr_q[$];
   logic        ack_r = 1'b0;
   logic        late_ack = 1'b0;
   logic        withhold = 1'b0;
   int          ack_lat = 0;
   int          cyc_age = 0;
   int          pulses = 0;
   int          stab_err = 0;
   logic        prev_cyc = 1'b0;
   logic [31:0] prev_adr = 32'd0;
   logic [31:0] prev_dat = 32'd0;

   assign i_wb_ack = ack_r | late_ack;

   always @(negedge clk) begin
      ack_r = 1'b0;
      if (i_rst) begin
         wr_q.delete();
         pulses   = 0;
         stab_err = 0;
         cyc_age  = 0;
         prev_cyc = 1'b0;
      end else begin
         if (o_wb_cyc) begin
            if (!prev_cyc) pulses++;
            if (prev_cyc && (o_wb_adr !== prev_adr || o_wb_dat !== prev_dat)) stab_err++;
            if (o_wb_sel !== 4'b1111 || o_wb_we !== 1'b1) stab_err++;
            if (!withhold && cyc_age == ack_lat) begin
               ack_r = 1'b1;
               wr_q.push_back('{adr: o_wb_adr, dat: o_wb_dat, sel: o_wb_sel, we: o_wb_we});
            end
            cyc_age++;
         end else begin
            cyc_age = 0;
         end
         prev_cyc = o_wb_cyc;
         prev_adr = o_wb_adr;
         prev_dat = o_wb_dat;
      end
   end

   // Byte driver: called at a falling edge, returns at the falling edge after acceptance
   task automatic send_byte(input logic [7:0] b, input logic gap);
      int t = 0;
      i_byte_valid = 1'b1;
      i_byte_data  = b;
      while (!o_byte_ready && t < 200) begin
         @(negedge clk);
         t++;
      end
      if (t >= 200) begin
         checks++;
         errors++;
         $display("FAIL send_byte: ready stayed %b for %0d cycles, required 1", o_byte_ready, t);
      end
      @(negedge clk);
      i_byte_valid = 1'b0;
      if (gap) @(negedge clk);
   endtask

   task automatic send_word(input logic [31:0] w, input logic gap);
      for (int k = 0; k < 4; k++) send_byte(w[8*k +: 8], gap);
   endtask

   task automatic do_reset();
      @(negedge clk);
      i_rst        = 1'b1;
      i_byte_valid = 1'b0;
      @(negedge clk);
      @(negedge clk);
      i_rst = 1'b0;
   endtask

   task automatic wait_end(input string name);
      int t = 0;
      while (!(o_done || o_err) && t < 300) begin
         @(negedge clk);
         t++;
      end
      check({name, "_finished_in_time"}, 32'(t < 300), 32'd1);
   endtask

   task automatic check_write(input string name, input int idx, input logic [31:0] adr,
                              input logic [31:0] dat);
      if (idx < wr_q.size()) begin
         check({name, "_adr"}, wr_q[idx].adr, adr);
         check({name, "_dat"}, wr_q[idx].dat, dat);
         check({name, "_sel"}, 32'(wr_q[idx].sel), 32'hF);
      end else begin
         check({name, "_present"}, 32'(wr_q.size()), 32'(idx + 1));
      end
   endtask

   typedef struct {
      string       name;
      logic [31:0] n;
      logic        exp_done;
      logic        exp_err;
      logic        exp_core_rst;
      logic        exp_ready;
   } len_vec_t;

   len_vec_t    len_tbl[6];
   logic [31:0] img_dat[4];
   logic [31:0] img_adr[4];
   int          cyc_cnt;

   initial begin
      len_tbl[0] = '{"len_zero",      32'd0,          1'b1, 1'b0, 1'b0, 1'b0};
      len_tbl[1] = '{"len_max_plus1", 32'd5,          1'b0, 1'b1, 1'b1, 1'b0};
      len_tbl[2] = '{"len_all_ones",  32'hFFFF_FFFF,  1'b0, 1'b1, 1'b1, 1'b0};
      len_tbl[3] = '{"len_high_byte", 32'h0100_0001,  1'b0, 1'b1, 1'b1, 1'b0};
      len_tbl[4] = '{"len_max",       32'd4,          1'b0, 1'b0, 1'b1, 1'b1};
      len_tbl[5] = '{"len_one",       32'd1,          1'b0, 1'b0, 1'b1, 1'b1};

      img_dat = '{32'h0102_0304, 32'hCAFE_F00D, 32'h8000_0001, 32'h5A5A_A5A5};
      img_adr = '{32'hFFFF_FFF8, 32'hFFFF_FFFC, 32'h0000_0000, 32'h0000_0004};

      // Reset state
      i_rst        = 1'b1;
      i_byte_valid = 1'b0;
      i_byte_data  = 8'h00;
      @(negedge clk);
      @(negedge clk);
      check("rst_cyc", 32'(o_wb_cyc), 32'd0);
      check("rst_we", 32'(o_wb_we), 32'd0);
      check("rst_sel", 32'(o_wb_sel), 32'd0);
      check("rst_core_rst", 32'(o_core_rst), 32'd1);
      check("rst_done", 32'(o_done), 32'd0);
      check("rst_err", 32'(o_err), 32'd0);
      check("rst_words", o_words_written, 32'd0);
      check("rst_ready", 32'(o_byte_ready), 32'd0);
      i_rst = 1'b0;
      @(negedge clk);
      check("ready_after_rst", 32'(o_byte_ready), 32'd1);

      // Length-stage vectors
      for (int i = 0; i < 6; i++) begin
         do_reset();
         send_word(len_tbl[i].n, 1'b0);
         check({len_tbl[i].name, "_done"}, 32'(o_done), 32'(len_tbl[i].exp_done));
         check({len_tbl[i].name, "_err"}, 32'(o_err), 32'(len_tbl[i].exp_err));
         check({len_tbl[i].name, "_core_rst"}, 32'(o_core_rst), 32'(len_tbl[i].exp_core_rst));
         check({len_tbl[i].name, "_ready"}, 32'(o_byte_ready), 32'(len_tbl[i].exp_ready));
         i_byte_valid = 1'b1;
         i_byte_data  = 8'hAA;
         repeat (3) @(negedge clk);
         i_byte_valid = 1'b0;
         check({len_tbl[i].name, "_no_cyc"}, 32'(pulses), 32'd0);
         check({len_tbl[i].name, "_done_sticky"}, 32'(o_done), 32'(len_tbl[i].exp_done));
         check({len_tbl[i].name, "_err_sticky"}, 32'(o_err), 32'(len_tbl[i].exp_err));
      end

      // Two-word image, ack one cycle after cyc
      do_reset();
      withhold = 1'b0;
      ack_lat  = 1;
      send_word(32'd2, 1'b0);
      send_word(32'h1234_5678, 1'b0);
      send_word(32'hDEAD_BEEF, 1'b0);
      wait_end("two_word");
      check("two_word_done", 32'(o_done), 32'd1);
      check("two_word_core_rst", 32'(o_core_rst), 32'd0);
      check("two_word_err", 32'(o_err), 32'd0);
      check("two_word_count", o_words_written, 32'd2);
      check("two_word_pulses", 32'(pulses), 32'd2);
      check("two_word_writes", 32'(wr_q.size()), 32'd2);
      check_write("two_word_w0", 0, BASE, 32'h1234_5678);
      check_write("two_word_w1", 1, BASE + 32'd4, 32'hDEAD_BEEF);
      check("two_word_stable", 32'(stab_err), 32'd0);
      i_byte_valid = 1'b1;
      repeat (3) @(negedge clk);
      i_byte_valid = 1'b0;
      check("two_word_ready_after_done", 32'(o_byte_ready), 32'd0);

      // Full-size image with address wrap, valid toggling, slower ack
      do_reset();
      ack_lat = 3;
      send_word(32'd4, 1'b1);
      for (int w = 0; w < 4; w++) send_word(img_dat[w], 1'b1);
      wait_end("wrap");
      check("wrap_done", 32'(o_done), 32'd1);
      check("wrap_count", o_words_written, 32'd4);
      check("wrap_pulses", 32'(pulses), 32'd4);
      for (int w = 0; w < 4; w++) check_write($sformatf("wrap_w%0d", w), w, img_adr[w], img_dat[w]);
      check("wrap_stable", 32'(stab_err), 32'd0);

      // Ack withheld: timeout after 16 cycles, late ack ignored
      do_reset();
      withhold = 1'b1;
      send_word(32'd1, 1'b0);
      send_word(32'h0BAD_F00D, 1'b0);
      cyc_cnt = 0;
      while (o_wb_cyc && cyc_cnt < 100) begin
         cyc_cnt++;
         @(negedge clk);
      end
      check("tmo_cyc_cycles", 32'(cyc_cnt), 32'd16);
      check("tmo_err", 32'(o_err), 32'd1);
      check("tmo_done", 32'(o_done), 32'd0);
      check("tmo_core_rst", 32'(o_core_rst), 32'd1);
      check("tmo_count", o_words_written, 32'd0);
      late_ack = 1'b1;
      @(negedge clk);
      late_ack = 1'b0;
      @(negedge clk);
      check("late_ack_count", o_words_written, 32'd0);
      check("late_ack_cyc", 32'(o_wb_cyc), 32'd0);
      check("late_ack_pulses", 32'(pulses), 32'd1);
      check("late_ack_ready", 32'(o_byte_ready), 32'd0);

      // Reset while the first write is outstanding, then a fresh one-word image
      do_reset();
      withhold = 1'b1;
      send_word(32'd2, 1'b0);
      send_word(32'hCAFE_BABE, 1'b0);
      check("abort_cyc_before", 32'(o_wb_cyc), 32'd1);
      i_rst = 1'b1;
      @(negedge clk);
      check("abort_cyc", 32'(o_wb_cyc), 32'd0);
      check("abort_core_rst", 32'(o_core_rst), 32'd1);
      check("abort_count", o_words_written, 32'd0);
      @(negedge clk);
      i_rst    = 1'b0;
      withhold = 1'b0;
      ack_lat  = 0;
      send_word(32'd1, 1'b0);
      send_word(32'h4433_2211, 1'b0);
      wait_end("restart");
      check("restart_done", 32'(o_done), 32'd1);
      check("restart_count", o_words_written, 32'd1);
      check("restart_pulses", 32'(pulses), 32'd1);
      check_write("restart_w0", 0, BASE, 32'h4433_2211);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
